// File: rtl/fetch_queue_stage.sv
// -----------------------------------------------------------------------------
// fetch_queue_stage
//
// Instruction-fetch stage with an in-order prefetch queue between imem and
// decode. Up to DEPTH requests/instructions are kept in flight so that imem
// latency is hidden behind decode stalls. BEQZ/BNEQZ redirects are resolved
// from the EX/MEM latch; responses still outstanding at a redirect are
// discarded as they come back.
//
// Optional feature macro: FETCH_STATS_EN
//   When defined, adds saturating 32-bit counters stat_fetched (pops),
//   stat_flushes (redirect cycles) and stat_dropped (discarded responses).
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   halt_f       1 = issue no new imem requests
//   ins_exmem    instruction in EX/MEM latch (opcode in [XLEN-1:XLEN-6])
//   cond_exmem   branch condition from EX/MEM
//   alu_exmem    branch target from EX/MEM
//   imem_req     fetch request strobe
//   imem_addr    fetch address (current PC)
//   imem_valid   in-order response valid, latency >= 1 cycle
//   imem_rdata   response instruction
//   id_valid     queue head valid
//   id_ready     decode accepts head
//   id_ins       head instruction
//   id_npc       head next-PC (fetch address + PC_INC)
//   flush        redirect taken this cycle
// -----------------------------------------------------------------------------
module fetch_queue_stage #(
   parameter int unsigned     XLEN     = 32,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter logic [XLEN-1:0] PC_INC   = XLEN'(1),
   parameter logic [5:0]      OP_BEQZ  = 6'b001100,
   parameter logic [5:0]      OP_BNEQZ = 6'b001101
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            halt_f,
   input  logic [XLEN-1:0] ins_exmem,
   input  logic            cond_exmem,
   input  logic [XLEN-1:0] alu_exmem,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_valid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [XLEN-1:0] id_ins,
   output logic [XLEN-1:0] id_npc,
   output logic            flush
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0]     stat_fetched,
   output logic [31:0]     stat_flushes,
   output logic [31:0]     stat_dropped
`endif
);

   localparam int unsigned AW      = $clog2(DEPTH);
   localparam int unsigned CW      = AW + 1;
   localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

   logic [5:0]      op;
   logic            taken;
   logic            issue;
   logic            push;
   logic            pop;
   logic            unused_ins;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_inc;
   logic [CW-1:0]   count;
   logic [CW-1:0]   inflight;
   logic [CW-1:0]   drop;
   logic [AW-1:0]   q_wp;
   logic [AW-1:0]   q_rp;
   logic [AW-1:0]   n_wp;
   logic [AW-1:0]   n_rp;
   logic [XLEN-1:0] ins_q   [DEPTH];
   logic [XLEN-1:0] npc_q   [DEPTH];
   logic [XLEN-1:0] req_npc [DEPTH];

   assign op         = ins_exmem[XLEN-1:XLEN-6];
   assign unused_ins = ^ins_exmem[XLEN-7:0];
   assign pc_inc     = pc + PC_INC;

   // Issue stage: redirect decode and credit check
   assign taken = ((op == OP_BEQZ) && cond_exmem) || ((op == OP_BNEQZ) && !cond_exmem);

   // Queue slots plus outstanding requests may never exceed DEPTH, which is
   // what guarantees a response always has a free slot to land in.
   assign issue = !halt_f && !taken && (({1'b0, count} + {1'b0, inflight}) < CREDITS);

   // The outputs are forced quiet while reset is held; internal state is
   // already pinned by the asynchronous clear.
   assign imem_req  = rst && issue;
   assign imem_addr = pc;
   assign flush     = rst && taken;

   // Response / handshake stage
   // A response arriving on the redirect edge belongs to the old stream.
   assign push     = imem_valid && (drop == '0) && !taken;
   assign id_valid = (count != '0);
   assign pop      = id_valid && id_ready && !taken;

   // Storage is not reset; an empty queue presents zeros instead.
   assign id_ins = id_valid ? ins_q[q_rp] : '0;
   assign id_npc = id_valid ? npc_q[q_rp] : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc       <= RESET_PC;
         count    <= '0;
         inflight <= '0;
         drop     <= '0;
         q_wp     <= '0;
         q_rp     <= '0;
         n_wp     <= '0;
         n_rp     <= '0;
      end else begin
         inflight <= inflight + CW'(issue) - CW'(imem_valid);
         if (taken) begin
            pc    <= alu_exmem + PC_INC;
            count <= '0;
            q_wp  <= '0;
            q_rp  <= '0;
            n_wp  <= '0;
            n_rp  <= '0;
            drop  <= inflight - CW'(imem_valid);
         end else begin
            if (issue) begin
               pc   <= pc_inc;
               n_wp <= n_wp + AW'(1);
            end
            if (push) begin
               q_wp <= q_wp + AW'(1);
               n_rp <= n_rp + AW'(1);
            end
            if (pop) begin
               q_rp <= q_rp + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
            if (imem_valid && (drop != '0)) begin
               drop <= drop - CW'(1);
            end
         end
      end
   end

   // Queue storage stage
   always_ff @(posedge clk) begin
      if (issue) begin
         req_npc[n_wp] <= pc_inc;
      end
      if (push) begin
         ins_q[q_wp] <= imem_rdata;
         npc_q[q_wp] <= req_npc[n_rp];
      end
   end

   a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
      !(push && !pop && (count == CW'(DEPTH))));

`ifdef FETCH_STATS_EN
   logic resp_drop;

   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
      return (en && (v != '1)) ? v + 32'd1 : v;
   endfunction

   assign resp_drop = imem_valid && ((drop != '0) || taken);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_fetched <= '0;
         stat_flushes <= '0;
         stat_dropped <= '0;
      end else begin
         stat_fetched <= sat_inc(stat_fetched, pop);
         stat_flushes <= sat_inc(stat_flushes, taken);
         stat_dropped <= sat_inc(stat_dropped, resp_drop);
      end
   end
`endif

endmodule

// File: tb/tb_fetch_queue_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue_stage
//
// Directed bench for fetch_queue_stage (XLEN=32, DEPTH=4). A small in-order
// imem model answers each request one cycle later with (addr+1)*0x11 unless
// responses are held back. A vector table covers redirect decode and issue
// gating; hand-written sequences cover the multi-cycle corner cases.
// -----------------------------------------------------------------------------
module tb_fetch_queue_stage;

   localparam int         XLEN  = 32;
   localparam logic [5:0] BEQZ  = 6'b001100;
   localparam logic [5:0] BNEQZ = 6'b001101;

   logic            clk    = 1'b0;
   logic            clk_en = 1'b0;
   logic            rst;
   logic            halt_f;
   logic [XLEN-1:0] ins_exmem;
   logic            cond_exmem;
   logic [XLEN-1:0] alu_exmem;
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_valid;
   logic [XLEN-1:0] imem_rdata;
   logic            id_valid;
   logic            id_ready;
   logic [XLEN-1:0] id_ins;
   logic [XLEN-1:0] id_npc;
   logic            flush;
`ifdef FETCH_STATS_EN
   logic [31:0]     stat_fetched;
   logic [31:0]     stat_flushes;
   logic [31:0]     stat_dropped;
`endif

   int n_cmp = 0;
   int n_err = 0;

   logic [XLEN-1:0] pend   [$];
   logic [XLEN-1:0] issued [$];
   logic [63:0]     got    [$];
   logic            hold;

   typedef struct packed {
      logic [XLEN-1:0] ins;
      logic            cond;
      logic            halt;
      logic            exp_flush;
      logic            exp_req;
   } vec_t;

   vec_t vecs [8];

   fetch_queue_stage dut (
      .clk        (clk),
      .rst        (rst),
      .halt_f     (halt_f),
      .ins_exmem  (ins_exmem),
      .cond_exmem (cond_exmem),
      .alu_exmem  (alu_exmem),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_valid (imem_valid),
      .imem_rdata (imem_rdata),
      .id_valid   (id_valid),
      .id_ready   (id_ready),
      .id_ins     (id_ins),
      .id_npc     (id_npc),
      .flush      (flush)
`ifdef FETCH_STATS_EN
      ,
      .stat_fetched (stat_fetched),
      .stat_flushes (stat_flushes),
      .stat_dropped (stat_dropped)
`endif
   );

   initial begin
      wait (clk_en);
      forever #5 clk = ~clk;
   end

   function automatic logic [XLEN-1:0] mem_word(input logic [XLEN-1:0] a);
      return (a + 32'd1) * 32'h11;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic chk_got(input int idx, input logic [XLEN-1:0] ins, input logic [XLEN-1:0] npc);
      if (idx < got.size()) begin
         chk($sformatf("delivered[%0d]", idx), got[idx], {ins, npc});
      end else begin
         n_cmp++;
         n_err++;
         $display("FAIL delivered[%0d]: actual none required %0h", idx, {ins, npc});
      end
   endtask

   task automatic model_refresh();
      imem_valid = !hold && (pend.size() > 0);
      imem_rdata = '0;
      if (imem_valid) imem_rdata = mem_word(pend[0]);
   endtask

   // One clock cycle: sample DUT outputs, cross the edge, advance imem model.
   task automatic tick();
      logic            req_s;
      logic [XLEN-1:0] addr_s;
      #1;
      req_s  = imem_req;
      addr_s = imem_addr;
      if (imem_req) issued.push_back(imem_addr);
      if (id_valid && id_ready) got.push_back({id_ins, id_npc});
      @(posedge clk);
      #1;
      if (imem_valid) pend.delete(0);
      if (req_s) pend.push_back(addr_s);
      model_refresh();
   endtask

   task automatic apply_reset();
      rst        = 1'b0;
      hold       = 1'b0;
      halt_f     = 1'b0;
      ins_exmem  = '0;
      cond_exmem = 1'b0;
      alu_exmem  = '0;
      id_ready   = 1'b1;
      pend.delete();
      issued.delete();
      got.delete();
      model_refresh();
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      vecs[0] = '{{BEQZ,  26'h0},       1'b1, 1'b0, 1'b1, 1'b0};
      vecs[1] = '{{BEQZ,  26'h0},       1'b0, 1'b0, 1'b0, 1'b1};
      vecs[2] = '{{BNEQZ, 26'h3ff},     1'b0, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{{BNEQZ, 26'h0},       1'b1, 1'b0, 1'b0, 1'b1};
      vecs[4] = '{{6'b001110, 26'h0},   1'b1, 1'b0, 1'b0, 1'b1};
      vecs[5] = '{32'h0000_000C,        1'b1, 1'b0, 1'b0, 1'b1};
      vecs[6] = '{32'h0,                1'b0, 1'b1, 1'b0, 1'b0};
      vecs[7] = '{{BNEQZ, 26'h0},       1'b0, 1'b1, 1'b1, 1'b0};

      rst        = 1'b0;
      hold       = 1'b0;
      halt_f     = 1'b0;
      ins_exmem  = '0;
      cond_exmem = 1'b0;
      alu_exmem  = '0;
      id_ready   = 1'b1;
      model_refresh();

      // Reset state, clock stopped
      #2;
      chk("rst imem_req", 64'(imem_req), 64'(0));
      chk("rst id_valid", 64'(id_valid), 64'(0));
      chk("rst id_ins",   64'(id_ins),   64'(0));
      chk("rst id_npc",   64'(id_npc),   64'(0));
      chk("rst flush",    64'(flush),    64'(0));
      rst = 1'b1;
      #1;
      chk("rel imem_req",  64'(imem_req),  64'(1));
      chk("rel imem_addr", 64'(imem_addr), 64'(0));
      chk("rel id_valid",  64'(id_valid),  64'(0));

      // Redirect decode / issue gating table, state idle
      for (int i = 0; i < 8; i++) begin
         ins_exmem  = vecs[i].ins;
         cond_exmem = vecs[i].cond;
         halt_f     = vecs[i].halt;
         #1;
         chk($sformatf("vec%0d flush", i),    64'(flush),    64'(vecs[i].exp_flush));
         chk($sformatf("vec%0d imem_req", i), 64'(imem_req), 64'(vecs[i].exp_req));
      end
      ins_exmem  = '0;
      cond_exmem = 1'b0;
      halt_f     = 1'b0;
      #1;
      clk_en = 1'b1;

      // Test 1: first fetches, latency and pairing
      tick();
      chk("t1 id_valid e1", 64'(id_valid), 64'(0));
      tick();
      chk("t1 id_valid e2", 64'(id_valid), 64'(1));
      chk("t1 id_ins e2",   64'(id_ins),   64'(32'h11));
      chk("t1 id_npc e2",   64'(id_npc),   64'(1));
      tick();
      chk("t1 id_ins e3",   64'(id_ins),   64'(32'h22));
      chk("t1 id_npc e3",   64'(id_npc),   64'(2));
      chk_got(0, 32'h11, 32'd1);

      // Test 2: backpressure fills the queue, then drains in order
      apply_reset();
      id_ready = 1'b0;
      repeat (6) tick();
      chk("t2 issued count", 64'(issued.size()), 64'(4));
      for (int i = 0; i < 4; i++) begin
         if (i < issued.size()) chk($sformatf("t2 issued[%0d]", i), 64'(issued[i]), 64'(i));
      end
      chk("t2 imem_req full", 64'(imem_req), 64'(0));
      repeat (2) tick();
      chk("t2 id_ins stable", 64'(id_ins),   64'(32'h11));
      chk("t2 id_npc stable", 64'(id_npc),   64'(1));
      chk("t2 still full",    64'(imem_req), 64'(0));
      id_ready = 1'b1;
      repeat (8) tick();
      chk_got(0, 32'h11, 32'd1);
      chk_got(1, 32'h22, 32'd2);
      chk_got(2, 32'h33, 32'd3);
      chk_got(3, 32'h44, 32'd4);
      chk_got(4, 32'h55, 32'd5);
      if (issued.size() > 4) chk("t2 resume addr", 64'(issued[4]), 64'(4));
      else chk("t2 resume count", 64'(issued.size()), 64'(5));

      // Test 3: BEQZ redirect with two requests outstanding
      apply_reset();
      hold = 1'b1;
      repeat (2) tick();
      ins_exmem  = {BEQZ, 26'h0};
      cond_exmem = 1'b1;
      alu_exmem  = 32'h40;
      hold       = 1'b0;
      #1;
      chk("t3 flush",    64'(flush),    64'(1));
      chk("t3 req gate", 64'(imem_req), 64'(0));
      tick();
      ins_exmem  = '0;
      cond_exmem = 1'b0;
      #1;
      chk("t3 flush off",  64'(flush),     64'(0));
      chk("t3 q empty",    64'(id_valid),  64'(0));
      chk("t3 new req",    64'(imem_req),  64'(1));
      chk("t3 new addr",   64'(imem_addr), 64'(32'h41));
      repeat (6) tick();
      chk_got(0, 32'h462, 32'h42);
      chk_got(1, 32'h473, 32'h43);
`ifdef FETCH_STATS_EN
      chk("t3 stat_flushes", 64'(stat_flushes), 64'(1));
      chk("t3 stat_dropped", 64'(stat_dropped), 64'(2));
`endif

      // Test 4: redirect on the same edge as a response
      apply_reset();
      hold = 1'b1;
      repeat (3) tick();
      hold = 1'b0;
      model_refresh();
      ins_exmem  = {BEQZ, 26'h0};
      cond_exmem = 1'b1;
      alu_exmem  = 32'h80;
      #1;
      chk("t4 flush", 64'(flush), 64'(1));
      tick();
      ins_exmem  = '0;
      cond_exmem = 1'b0;
      #1;
      chk("t4 id_valid e4", 64'(id_valid),  64'(0));
      chk("t4 new addr",    64'(imem_addr), 64'(32'h81));
      tick();
      chk("t4 id_valid e5", 64'(id_valid), 64'(0));
      tick();
      chk("t4 id_valid e6", 64'(id_valid), 64'(0));
      tick();
      chk("t4 id_valid e7", 64'(id_valid), 64'(1));
      chk("t4 id_ins e7",   64'(id_ins),   64'(32'h8A2));
      chk("t4 id_npc e7",   64'(id_npc),   64'(32'h82));
`ifdef FETCH_STATS_EN
      chk("t4 stat_dropped", 64'(stat_dropped), 64'(3));
`endif

      // Test 5: halt with three requests outstanding
      apply_reset();
      hold = 1'b1;
      repeat (3) tick();
      halt_f = 1'b1;
      hold   = 1'b0;
      model_refresh();
      #1;
      chk("t5 halt req", 64'(imem_req), 64'(0));
      repeat (5) tick();
      chk("t5 no issue", 64'(issued.size()), 64'(3));
      chk_got(0, 32'h11, 32'd1);
      chk_got(1, 32'h22, 32'd2);
      chk_got(2, 32'h33, 32'd3);
      chk("t5 drained", 64'(id_valid), 64'(0));
      halt_f = 1'b0;
      #1;
      chk("t5 resume req",  64'(imem_req),  64'(1));
      chk("t5 resume addr", 64'(imem_addr), 64'(3));
      repeat (4) tick();
      chk_got(3, 32'h44, 32'd4);

      // Test 6: reset mid-stream with the queue full
      apply_reset();
      id_ready = 1'b0;
      repeat (6) tick();
      chk("t6 full pre", 64'(id_valid), 64'(1));
      rst = 1'b0;
      pend.delete();
      got.delete();
      issued.delete();
      model_refresh();
      #1;
      chk("t6 imem_req", 64'(imem_req), 64'(0));
      chk("t6 id_valid", 64'(id_valid), 64'(0));
      chk("t6 id_ins",   64'(id_ins),   64'(0));
      chk("t6 id_npc",   64'(id_npc),   64'(0));
      chk("t6 flush",    64'(flush),    64'(0));
`ifdef FETCH_STATS_EN
      chk("t6 stat_fetched", 64'(stat_fetched), 64'(0));
      chk("t6 stat_flushes", 64'(stat_flushes), 64'(0));
      chk("t6 stat_dropped", 64'(stat_dropped), 64'(0));
`endif
      @(posedge clk);
      #1;
      rst      = 1'b1;
      id_ready = 1'b1;
      #1;
      chk("t6 rel addr", 64'(imem_addr), 64'(0));
      chk("t6 rel req",  64'(imem_req),  64'(1));
      repeat (3) tick();
      chk_got(0, 32'h11, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
